// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared widths and result type for the pipelined 16-bit subtractor
// Contents: WIDTH / LO_WIDTH / HI_WIDTH slice widths, sub_res_t registered result bundle.
package sub_pkg;

  localparam int WIDTH    = 16;
  localparam int LO_WIDTH = 8;
  localparam int HI_WIDTH = WIDTH - LO_WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] D;
    logic             B_out;
    logic             V;
    logic             Z;
  } sub_res_t;

endpackage

// File: rtl/sub_8_bit.sv
// rtl/sub_8_bit.sv - combinational slice subtractor: diff = a - b - bin
// Ports:
//   a, b   in  W  operands (unsigned)
//   bin    in  1  borrow in
//   diff   out W  difference modulo 2^W
//   bout   out 1  borrow out, 1 iff a < b + bin
module sub_8_bit
  import sub_pkg::*;
#(
  parameter int W = LO_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  // One extra bit catches the borrow: a negative result wraps so the top bit is set.
  logic [W:0] full;

  assign full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign diff = full[W-1:0];
  assign bout = full[W];

endmodule

// File: rtl/sub_16_bit_pipe.sv
// rtl/sub_16_bit_pipe.sv - two-stage valid/ready 16-bit subtractor D = A - B - B_in
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   input handshake; A, B, B_in sampled on transfer
//   A, B, B_in           minuend, subtrahend, borrow in
//   out_valid, out_ready output handshake
//   D, B_out, V, Z       difference, borrow out, signed overflow, zero flag (registered)
module sub_16_bit_pipe
  import sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             B_out,
  output logic             V,
  output logic             Z
);

  // Stage 1 registers: low slice result plus the untouched high operand bytes.
  logic                s1_valid;
  logic [LO_WIDTH-1:0] s1_d_lo;
  logic                s1_b1;
  logic [HI_WIDTH-1:0] s1_a_hi;
  logic [HI_WIDTH-1:0] s1_b_hi;

  // Stage 2 (output) register.
  sub_res_t res;

  logic [LO_WIDTH-1:0] lo_diff;
  logic                lo_bout;
  logic [HI_WIDTH-1:0] hi_diff;
  logic                hi_bout;
  logic [WIDTH-1:0]    d_next;
  logic                v_next;
  logic                s2_ready;

  // Ready ripples back combinationally so a full pipe can pop and push in one cycle.
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  sub_8_bit #(.W(LO_WIDTH)) u_lo (
    .a    (A[LO_WIDTH-1:0]),
    .b    (B[LO_WIDTH-1:0]),
    .bin  (B_in),
    .diff (lo_diff),
    .bout (lo_bout)
  );

  // The high slice only sees the registered borrow, so no path from A[7:0] reaches D[15:8].
  sub_8_bit #(.W(HI_WIDTH)) u_hi (
    .a    (s1_a_hi),
    .b    (s1_b_hi),
    .bin  (s1_b1),
    .diff (hi_diff),
    .bout (hi_bout)
  );

  assign d_next = {hi_diff, s1_d_lo};
  assign v_next = (s1_a_hi[HI_WIDTH-1] != s1_b_hi[HI_WIDTH-1]) &&
                  (hi_diff[HI_WIDTH-1] != s1_a_hi[HI_WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_d_lo  <= '0;
      s1_b1    <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_d_lo <= lo_diff;
        s1_b1   <= lo_bout;
        s1_a_hi <= A[WIDTH-1:LO_WIDTH];
        s1_b_hi <= B[WIDTH-1:LO_WIDTH];
      end
    end
  end

  // Result fields only change when a new result moves in; they hold through stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        res.D     <= d_next;
        res.B_out <= hi_bout;
        res.V     <= v_next;
        res.Z     <= (d_next == '0);
      end
    end
  end

  assign D     = res.D;
  assign B_out = res.B_out;
  assign V     = res.V;
  assign Z     = res.Z;

endmodule
